// File: rtl/router_dest_reader.sv
// Destination-port packet sink for the 1x3 router: pops header, payload and
// parity from the port FIFO, checks parity, streams payload and counts packets.
module router_dest_reader #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vld_out,
  input  logic [7:0]       data_out,
  output logic             read_enb,
  input  logic [4:0]       rd_delay,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sop,
  output logic             rx_eop,
  output logic             pkt_done,
  output logic [1:0]       pkt_addr,
  output logic [5:0]       pkt_len,
  output logic             parity_err,
  output logic             trunc_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ
  } state_t;

  state_t state, state_nx;

  logic          rd_want;
  logic          rd_q;
  logic [4:0]    dly_cnt;
  logic [6:0]    issued;
  logic [6:0]    cap_cnt;
  logic [IW-1:0] idle_cnt;
  logic [7:0]    acc;

  logic       pop;
  logic       hdr_cap;
  logic       last_cap;
  logic       pay_cap;
  logic       stall_to;
  logic       start_rd;
  logic       bad_par;
  logic [6:0] len_eff;
  logic [6:0] total_eff;

  assign read_enb = rd_want && vld_out;
  assign pop      = read_enb;

  // Length is taken straight from the bus on the header capture so that
  // a zero-length packet can stop popping in the same cycle.
  assign hdr_cap   = rd_q && (cap_cnt == 7'd0);
  assign len_eff   = hdr_cap ? {1'b0, data_out[7:2]} : {1'b0, pkt_len};
  assign total_eff = len_eff + 7'd2;
  assign last_cap  = rd_q && !hdr_cap && (cap_cnt == len_eff + 7'd1);
  assign pay_cap   = rd_q && !hdr_cap && !last_cap;
  assign bad_par   = acc != data_out;
  assign stall_to  = (state == READ) && !vld_out &&
                     (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_rd = 1'b0;
    unique case (state)
      IDLE: if (vld_out) state_nx = WAIT;
      WAIT: begin
        if (!vld_out) begin
          state_nx = IDLE;
        end else if (dly_cnt == 5'd0) begin
          state_nx = READ;
          start_rd = 1'b1;
        end
      end
      READ: if (last_cap || stall_to) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_want    <= 1'b0;
      rd_q       <= 1'b0;
      dly_cnt    <= '0;
      issued     <= '0;
      cap_cnt    <= '0;
      idle_cnt   <= '0;
      acc        <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_addr   <= '0;
      pkt_len    <= '0;
      parity_err <= 1'b0;
      trunc_err  <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_sop   <= 1'b0;
      rx_eop   <= 1'b0;
      pkt_done <= 1'b0;
      rd_q     <= pop;

      if (state == IDLE && vld_out) begin
        dly_cnt <= rd_delay;
      end else if (state == WAIT && dly_cnt != 5'd0) begin
        dly_cnt <= dly_cnt - 5'd1;
      end

      if (start_rd) begin
        rd_want  <= 1'b1;
        issued   <= '0;
        cap_cnt  <= '0;
        idle_cnt <= '0;
      end

      if (pop) begin
        issued   <= issued + 7'd1;
        idle_cnt <= '0;
        if (issued + 7'd1 == total_eff) rd_want <= 1'b0;
      end else if (state == READ && !vld_out) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (rd_q) cap_cnt <= cap_cnt + 7'd1;

      if (hdr_cap) begin
        pkt_addr <= data_out[1:0];
        pkt_len  <= data_out[7:2];
        acc      <= data_out;
      end

      if (pay_cap) begin
        acc      <= acc ^ data_out;
        rx_valid <= 1'b1;
        rx_data  <= data_out;
        rx_sop   <= cap_cnt == 7'd1;
        rx_eop   <= cap_cnt == {1'b0, pkt_len};
      end

      if (last_cap) begin
        pkt_done   <= 1'b1;
        parity_err <= bad_par;
        trunc_err  <= 1'b0;
        if (bad_par) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end else begin
          if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
        end
      end

      if (stall_to) begin
        pkt_done   <= 1'b1;
        parity_err <= 1'b0;
        trunc_err  <= 1'b1;
        rd_want    <= 1'b0;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_router_dest_reader.sv
// Directed bench for router_dest_reader with a small FIFO source model
// and a negedge monitor collecting payload and packet-done events.
module tb_router_dest_reader;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             vld_out;
  logic [7:0]       data_out = 8'h00;
  logic             read_enb;
  logic [4:0]       rd_delay = 5'd0;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_sop;
  logic             rx_eop;
  logic             pkt_done;
  logic [1:0]       pkt_addr;
  logic [5:0]       pkt_len;
  logic             parity_err;
  logic             trunc_err;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  logic       gap = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] src_mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  logic [7:0] rx_q [$];
  logic [1:0] fl_q [$];
  int         done_cnt = 0;
  int         done_ptr = 0;

  int passed = 0;
  int total  = 0;

  router_dest_reader #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .rd_delay   (rd_delay),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .pkt_done   (pkt_done),
    .pkt_addr   (pkt_addr),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .trunc_err  (trunc_err),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clock = ~clock;

  assign vld_out = (rd_ptr != wr_ptr) && !gap;

  always @(posedge clock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (read_enb) begin
      data_out <= src_mem[rd_ptr[9:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  always @(negedge clock) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      fl_q.push_back({rx_sop, rx_eop});
    end
    if (pkt_done) begin
      done_cnt = done_cnt + 1;
      done_ptr = rd_ptr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return 32'({rx_valid, rx_sop, rx_eop, pkt_done, parity_err,
                trunc_err, pkt_addr, pkt_len, rx_data});
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] base,
                                          input int i);
    return base + 8'(i * 17);
  endfunction

  task automatic push(input logic [7:0] b);
    src_mem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  // limit < 0 pushes the whole packet; otherwise only the first bytes
  task automatic push_pkt(input logic [1:0] a, input logic [5:0] l,
                          input logic [7:0] base, input logic [7:0] pmask,
                          input int limit);
    logic [7:0] h;
    logic [7:0] p;
    logic [7:0] b;
    int n;
    h = {l, a};
    p = h;
    n = 0;
    if (limit < 0 || n < limit) begin push(h); n++; end
    for (int i = 0; i < int'(l); i++) begin
      b = exp_byte(base, i);
      p = p ^ b;
      if (limit < 0 || n < limit) begin push(b); n++; end
    end
    if (limit < 0 || n < limit) push(p ^ pmask);
  endtask

  task automatic wait_done(input string tag);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, 32'(done_cnt != start), 1);
  endtask

  task automatic wait_ptr(input int target, input string tag);
    int n;
    n = 0;
    while (rd_ptr < target && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, 32'(rd_ptr >= target), 1);
  endtask

  task automatic first_rd(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (!read_enb && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, n, exp_lat);
  endtask

  task automatic check_pkt(input int s, input logic [7:0] base,
                           input int len, input string tag);
    logic [1:0] fl;
    check({tag, "_cnt"}, rx_q.size() - s, len);
    for (int i = 0; i < len; i++) begin
      if (s + i < rx_q.size()) begin
        fl = {1'(i == 0), 1'(i == len - 1)};
        check({tag, "_byte"}, 32'({fl_q[s+i], rx_q[s+i]}),
              32'({fl, exp_byte(base, i)}));
      end
    end
  endtask

  initial begin
    int s;
    int p0;
    int n;
    logic seen;

    repeat (3) @(posedge clock);
    #1;
    check("rst_rd", 32'(read_enb), 0);
    check("rst_out", outs(), 0);
    check("rst_cnt", 32'({pkt_cnt, err_cnt}), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // good packet, zero delay
    s = rx_q.size();
    push_pkt(2'd1, 6'd3, 8'hA1, 8'h00, -1);
    first_rd(2, "t1_lat");
    wait_done("t1_done");
    check_pkt(s, 8'hA1, 3, "t1");
    check("t1_hdr", 32'({pkt_addr, pkt_len}), 32'({2'd1, 6'd3}));
    check("t1_flags", 32'({parity_err, trunc_err}), 0);
    check("t1_cnt", 32'({pkt_cnt, err_cnt}), 32'({16'd1, 16'd0}));
    repeat (3) @(posedge clock); #1;

    // corrupted parity
    push_pkt(2'd1, 6'd3, 8'hA1, 8'h01, -1);
    wait_done("t2_done");
    check("t2_flags", 32'({parity_err, trunc_err}), 32'({1'b1, 1'b0}));
    check("t2_cnt", 32'({pkt_cnt, err_cnt}), 32'({16'd1, 16'd1}));
    repeat (3) @(posedge clock); #1;

    // two back-to-back zero-length packets with a read delay
    rd_delay = 5'd3;
    s = rx_q.size();
    p0 = wr_ptr;
    push_pkt(2'd2, 6'd0, 8'h00, 8'h00, -1);
    push_pkt(2'd3, 6'd0, 8'h00, 8'h00, -1);
    first_rd(5, "t3_lat");
    wait_done("t3a_done");
    check("t3_pops", done_ptr - p0, 2);
    check("t3a_hdr", 32'({pkt_addr, pkt_len, parity_err}),
          32'({2'd2, 6'd0, 1'b0}));
    wait_done("t3b_done");
    check("t3b_hdr", 32'({pkt_addr, pkt_len, parity_err}),
          32'({2'd3, 6'd0, 1'b0}));
    check("t3_norx", rx_q.size() - s, 0);
    check("t3_cnt", 32'({pkt_cnt, err_cnt}), 32'({16'd3, 16'd1}));
    rd_delay = 5'd0;
    repeat (3) @(posedge clock); #1;

    // stall mid-payload shorter than the timeout
    s = rx_q.size();
    p0 = wr_ptr;
    push_pkt(2'd0, 6'd10, 8'h10, 8'h00, -1);
    wait_ptr(p0 + 5, "t4_ptr");
    gap = 1'b1;
    n = rd_ptr;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      if (read_enb) seen = 1'b1;
    end
    check("t4_gap_rd", 32'(seen), 0);
    check("t4_gap_ptr", rd_ptr - n, 0);
    gap = 1'b0;
    wait_done("t4_done");
    check_pkt(s, 8'h10, 10, "t4");
    check("t4_flags", 32'({parity_err, trunc_err}), 0);
    check("t4_cnt", 32'({pkt_cnt, err_cnt}), 32'({16'd4, 16'd1}));
    repeat (3) @(posedge clock); #1;

    // truncated packet: source dries up after two payload bytes
    s = rx_q.size();
    push_pkt(2'd0, 6'd5, 8'h40, 8'h00, 3);
    n = 0;
    while (rd_ptr != wr_ptr && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("t5_drain", 32'(rd_ptr == wr_ptr), 1);
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (pkt_done) break;
    end
    check("t5_lat", n, 17);
    @(posedge clock); #1;
    check("t5_flags", 32'({parity_err, trunc_err}), 32'({1'b0, 1'b1}));
    check("t5_cnt", 32'({pkt_cnt, err_cnt}), 32'({16'd4, 16'd2}));
    check("t5_rx", rx_q.size() - s, 2);
    repeat (3) @(posedge clock); #1;
    s = rx_q.size();
    push_pkt(2'd2, 6'd2, 8'h55, 8'h00, -1);
    first_rd(2, "t5n_lat");
    wait_done("t5n_done");
    check_pkt(s, 8'h55, 2, "t5n");
    check("t5n_flags", 32'({pkt_addr, parity_err, trunc_err}),
          32'({2'd2, 1'b0, 1'b0}));
    check("t5n_cnt", 32'({pkt_cnt, err_cnt}), 32'({16'd5, 16'd2}));
    repeat (3) @(posedge clock); #1;

    // reset in the middle of a long packet
    p0 = wr_ptr;
    push_pkt(2'd1, 6'd20, 8'h07, 8'h00, -1);
    wait_ptr(p0 + 5, "t6_ptr");
    n = done_cnt;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clock); #1;
    check("t6_rd", 32'(read_enb), 0);
    check("t6_out", outs(), 0);
    check("t6_cnt", 32'({pkt_cnt, err_cnt}), 0);
    reset = 1'b0;
    flush = 1'b0;
    repeat (30) @(posedge clock); #1;
    check("t6_nodone", done_cnt - n, 0);
    check("t6_idle", 32'({read_enb, pkt_cnt, err_cnt}), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
